inst_trace_pub: RTL and testbench
=================================

# inst_trace_pub

In-order instruction-trace publisher: the producing end of the InstTraceNotif interface that InstTraceSub consumes. It allocates sequence numbers at dispatch, accepts out-of-order writeback completions tagged with those numbers, and emits exactly one trace notification per instruction in program order. It sits between the BlimpV4 out-of-order back end and the `inst_trace` port.

## Interface

Parameters:
- p_seq_num_bits, 5, sequence-number width; reorder depth is 2^p_seq_num_bits entries

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- alloc_val  input  1  dispatch requests a sequence number this cycle
- alloc_rdy  output  1  an entry is free; allocation fires when alloc_val && alloc_rdy
- alloc_seq_num  output  p_seq_num_bits  number granted on a firing allocation (tail pointer)
- cmpl_val  input  1  a completion is presented this cycle
- cmpl_seq_num  input  p_seq_num_bits  entry being completed
- cmpl_pc  input  32  PC of completing instruction
- cmpl_waddr  input  5  architectural destination register
- cmpl_wdata  input  32  value written
- cmpl_wen  input  1  instruction writes a register
- trace_pc  output  32  InstTraceNotif pc
- trace_waddr  output  5  InstTraceNotif waddr
- trace_wdata  output  32  InstTraceNotif wdata
- trace_wen  output  1  InstTraceNotif wen
- trace_val  output  1  InstTraceNotif val; one-cycle notification, no back-pressure
- empty  output  1  no allocated entries

## Operation

- Storage: 2^p_seq_num_bits entries, each {alloc, done, pc, waddr, wdata, wen}; head and tail pointers p_seq_num_bits wide, wrap modulo depth; occupancy counter p_seq_num_bits+1 wide.
- Allocate: on fire, entry[tail].alloc<=1, done<=0, tail<=tail+1, count+1.
- alloc_rdy = (count != depth), computed from registered count; a commit in the same cycle does not free a slot for that cycle's allocation.
- Complete: if cmpl_val and entry[cmpl_seq_num].alloc && !done, store payload and set done. Completion to an unallocated or already-done entry is ignored (no state change).
- Commit: when entry[head].alloc && done, drive trace_* from entry[head], trace_val=1; at the edge clear alloc/done, head<=head+1, count-1. At most one commit per cycle.
- Simultaneous allocate, complete and commit in one cycle are all legal; count changes by (+1 alloc) + (-1 commit).
- When trace_val=0, trace_pc/waddr/wdata are 0 and trace_wen is 0.
- empty = (count == 0).

## Timing

- Reset (rst low, asynchronous): head=tail=0, count=0, all alloc/done=0; outputs: alloc_rdy=1, alloc_seq_num=0, trace_val=0, trace_* =0, empty=1. Asserting rst mid-operation discards all entries; no trace is emitted for them.
- alloc_seq_num is valid combinationally in the allocation cycle.
- Completion written in cycle N → earliest trace_val for that entry in cycle N+1 (base build).
- Back-to-back completed entries commit at one per cycle.
- Wrap-around: after seq 2^p_seq_num_bits-1 the next grant is 0; order preserved across wrap.

## Configuration

- INST_TRACE_PUB_BYPASS_EN defined: if cmpl_val targets head (allocated, not done) in cycle N, trace_* is driven from the cmpl_* inputs and trace_val=1 in cycle N; the head commits at that edge without writing the entry. Latency 0.
- Undefined: no bypass; head completion commits in cycle N+1 as above. Tests must pass in both builds, with latency checks parameterised.

## Test plan

- Reset: rst low mid-run with 3 entries allocated → trace_val=0, empty=1, alloc_rdy=1, next grant alloc_seq_num=0.
- In-order: allocate 0,1,2; complete 0,1,2 in successive cycles (pc 0x200,0x204,0x208, wen=1) → three traces in cycles N+1..N+3 (N..N+2 with bypass), in that order.
- Out-of-order: allocate 0..3; complete 3,1,2,0 → no trace until 0 completes, then pc order 0,1,2,3 on four consecutive cycles.
- Full: 32 allocations → alloc_rdy=0 on the 33rd; alloc+commit same cycle → allocation refused that cycle, accepted next.
- Wrap: run 40 instructions through depth 32 → alloc_seq_num wraps 31→0; traces match expected program order with wdata intact.
- Illegal completions: complete unallocated seq 7 and duplicate-complete seq 0 with wdata 0xDEAD → ignored; original wdata traced.

Source files
------------

// File: rtl/inst_trace_pub.sv
// inst_trace_pub: in-order instruction-trace publisher.
// Dispatch gets sequence numbers in order. Writeback completions may arrive
// out of order and are parked in a reorder table. Exactly one trace
// notification is published per instruction, in program order.
// Build option: define INST_TRACE_PUB_BYPASS_EN to let a completion that
// targets the head entry publish in the same cycle.
module inst_trace_pub #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  input  logic                      cmpl_val,
  input  logic [p_seq_num_bits-1:0] cmpl_seq_num,
  input  logic [31:0]               cmpl_pc,
  input  logic [4:0]                cmpl_waddr,
  input  logic [31:0]               cmpl_wdata,
  input  logic                      cmpl_wen,
  output logic [31:0]               trace_pc,
  output logic [4:0]                trace_waddr,
  output logic [31:0]               trace_wdata,
  output logic                      trace_wen,
  output logic                      trace_val,
  output logic                      empty
);

  localparam int SW    = p_seq_num_bits;
  localparam int CW    = p_seq_num_bits + 1;
  localparam int DEPTH = 2 ** p_seq_num_bits;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] ent_alloc;
  logic [DEPTH-1:0] ent_done;
  logic [31:0]      ent_pc    [DEPTH];
  logic [4:0]       ent_waddr [DEPTH];
  logic [31:0]      ent_wdata [DEPTH];
  logic             ent_wen   [DEPTH];

  logic [SW-1:0] head;
  logic [SW-1:0] tail;
  logic [CW-1:0] count;

  logic alloc_fire;
  logic cmpl_ok;
  logic cmpl_wr;
  logic head_ready;
  logic bypass_hit;
  logic commit;

  // Handshake, acceptance and commit decisions
  always_comb begin
    alloc_rdy     = (count != FULL_CNT);
    alloc_fire    = alloc_val && alloc_rdy;
    alloc_seq_num = tail;
    empty         = (count == '0);
    cmpl_ok       = cmpl_val && ent_alloc[cmpl_seq_num] && !ent_done[cmpl_seq_num];
    head_ready    = ent_alloc[head] && ent_done[head];
`ifdef INST_TRACE_PUB_BYPASS_EN
    bypass_hit    = cmpl_ok && (cmpl_seq_num == head);
`else
    bypass_hit    = 1'b0;
`endif
    // A bypassed head never needs its payload stored: it retires this edge.
    commit        = head_ready || bypass_hit;
    cmpl_wr       = cmpl_ok && !bypass_hit;
  end

  // Trace notification; all fields held at zero when nothing is published
  always_comb begin
    trace_val   = 1'b0;
    trace_pc    = '0;
    trace_waddr = '0;
    trace_wdata = '0;
    trace_wen   = 1'b0;
    if (bypass_hit) begin
      trace_val   = 1'b1;
      trace_pc    = cmpl_pc;
      trace_waddr = cmpl_waddr;
      trace_wdata = cmpl_wdata;
      trace_wen   = cmpl_wen;
    end else if (head_ready) begin
      trace_val   = 1'b1;
      trace_pc    = ent_pc[head];
      trace_waddr = ent_waddr[head];
      trace_wdata = ent_wdata[head];
      trace_wen   = ent_wen[head];
    end
  end

  // Entry flags, pointers and occupancy. Tail and head only alias on a
  // commit when the table is full, where no allocation can fire, so the
  // alloc and commit updates never target the same entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_alloc <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (alloc_fire) begin
        ent_alloc[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + SW'(1);
      end
      if (cmpl_wr) begin
        ent_done[cmpl_seq_num] <= 1'b1;
      end
      if (commit) begin
        ent_alloc[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + SW'(1);
      end
      case ({alloc_fire, commit})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Completion payload storage; contents are meaningless until done is set
  always_ff @(posedge clk) begin
    if (cmpl_wr) begin
      ent_pc[cmpl_seq_num]    <= cmpl_pc;
      ent_waddr[cmpl_seq_num] <= cmpl_waddr;
      ent_wdata[cmpl_seq_num] <= cmpl_wdata;
      ent_wen[cmpl_seq_num]   <= cmpl_wen;
    end
  end

endmodule

// File: tb/tb_inst_trace_pub.sv
// Directed self-checking bench for inst_trace_pub (depth 32). Expected
// commit latency follows the INST_TRACE_PUB_BYPASS_EN build option.
module tb_inst_trace_pub;

  localparam int SW    = 5;
  localparam int DEPTH = 32;
`ifdef INST_TRACE_PUB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    int          cyc;
  } tr_t;

  logic          clk;
  logic          rst;
  logic          alloc_val;
  logic          alloc_rdy;
  logic [SW-1:0] alloc_seq_num;
  logic          cmpl_val;
  logic [SW-1:0] cmpl_seq_num;
  logic [31:0]   cmpl_pc;
  logic [4:0]    cmpl_waddr;
  logic [31:0]   cmpl_wdata;
  logic          cmpl_wen;
  logic [31:0]   trace_pc;
  logic [4:0]    trace_waddr;
  logic [31:0]   trace_wdata;
  logic          trace_wen;
  logic          trace_val;
  logic          empty;

  int  checks = 0;
  int  errors = 0;
  int  cyc_n  = 0;
  tr_t tq[$];

  inst_trace_pub #(.p_seq_num_bits(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_val     (alloc_val),
    .alloc_rdy     (alloc_rdy),
    .alloc_seq_num (alloc_seq_num),
    .cmpl_val      (cmpl_val),
    .cmpl_seq_num  (cmpl_seq_num),
    .cmpl_pc       (cmpl_pc),
    .cmpl_waddr    (cmpl_waddr),
    .cmpl_wdata    (cmpl_wdata),
    .cmpl_wen      (cmpl_wen),
    .trace_pc      (trace_pc),
    .trace_waddr   (trace_waddr),
    .trace_wdata   (trace_wdata),
    .trace_wen     (trace_wen),
    .trace_val     (trace_val),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  // Record every published trace with the cycle it appeared in
  always @(negedge clk) begin
    if (trace_val === 1'b1)
      tq.push_back('{pc: trace_pc, waddr: trace_waddr, wdata: trace_wdata,
                     wen: trace_wen, cyc: cyc_n});
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic tr_t get_tr(input int i);
    tr_t t;
    t = '{pc: 32'h0, waddr: 5'h0, wdata: 32'h0, wen: 1'b0, cyc: -1};
    if (i < tq.size()) t = tq[i];
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    alloc_val    = 1'b0;
    cmpl_val     = 1'b0;
    cmpl_seq_num = '0;
    cmpl_pc      = '0;
    cmpl_waddr   = '0;
    cmpl_wdata   = '0;
    cmpl_wen     = 1'b0;
  endtask

  task automatic cmpl(input int seq, input logic [31:0] pc, input logic [4:0] wa,
                      input logic [31:0] wd, input logic we);
    cmpl_val     = 1'b1;
    cmpl_seq_num = SW'(seq);
    cmpl_pc      = pc;
    cmpl_waddr   = wa;
    cmpl_wdata   = wd;
    cmpl_wen     = we;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int  n0;
    int  hit;
    int  at;
    int  ci;
    tr_t t;

    rst = 1'b0;
    idle_in();

    // Power-on reset values
    step();
    settle();
    check("por_alloc_rdy", 64'(alloc_rdy), 64'd1);
    check("por_seq", 64'(alloc_seq_num), 64'd0);
    check("por_empty", 64'(empty), 64'd1);
    check("por_trace_val", 64'(trace_val), 64'd0);
    step();
    rst = 1'b1;
    step();

    // In-order completion
    tq.delete();
    for (int i = 0; i < 3; i++) begin
      alloc_val = 1'b1;
      settle();
      check($sformatf("io_grant%0d", i), 64'(alloc_seq_num), 64'(i));
      step();
    end
    alloc_val = 1'b0;
    settle();
    check("io_not_empty", 64'(empty), 64'd0);
    step();
    n0 = cyc_n;
    for (int i = 0; i < 3; i++) begin
      cmpl(i, 32'h200 + 32'(4 * i), 5'(i + 1), 32'h1000 + 32'(i), 1'b1);
      step();
    end
    idle_in();
    repeat (3) step();
    settle();
    check("io_count", 64'(tq.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      t = get_tr(i);
      check($sformatf("io_pc%0d", i), 64'(t.pc), 64'(32'h200 + 32'(4 * i)));
      check($sformatf("io_wdata%0d", i), 64'(t.wdata), 64'(32'h1000 + 32'(i)));
      check($sformatf("io_cyc%0d", i), 64'(t.cyc), 64'(n0 + i + LAT));
    end
    check("idle_trace_val", 64'(trace_val), 64'd0);
    check("idle_trace_pc", 64'(trace_pc), 64'd0);
    check("idle_trace_wdata", 64'(trace_wdata), 64'd0);
    check("idle_trace_wen", 64'(trace_wen), 64'd0);
    check("io_empty", 64'(empty), 64'd1);

    // Asynchronous reset with three live entries (seq 3,4,5; seq 4 done)
    tq.delete();
    step();
    alloc_val = 1'b1;
    repeat (3) step();
    alloc_val = 1'b0;
    cmpl(4, 32'h500, 5'd4, 32'h5555, 1'b1);
    step();
    idle_in();
    #1;
    rst = 1'b0;
    #1;
    check("rst_trace_val", 64'(trace_val), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_alloc_rdy", 64'(alloc_rdy), 64'd1);
    check("rst_seq", 64'(alloc_seq_num), 64'd0);
    step();
    step();
    rst = 1'b1;
    repeat (2) step();
    check("rst_no_trace", 64'(tq.size()), 64'd0);

    // Out-of-order completion 3,1,2,0
    tq.delete();
    for (int i = 0; i < 4; i++) begin
      alloc_val = 1'b1;
      settle();
      check($sformatf("ooo_grant%0d", i), 64'(alloc_seq_num), 64'(i));
      step();
    end
    alloc_val = 1'b0;
    cmpl(3, 32'h30C, 5'd3, 32'hC003, 1'b1);
    step();
    cmpl(1, 32'h304, 5'd1, 32'hC001, 1'b1);
    step();
    cmpl(2, 32'h308, 5'd2, 32'hC002, 1'b0);
    step();
    idle_in();
    step();
    settle();
    check("ooo_hold", 64'(tq.size()), 64'd0);
    n0 = cyc_n;
    cmpl(0, 32'h300, 5'd0, 32'hC000, 1'b1);
    step();
    idle_in();
    repeat (5) step();
    check("ooo_count", 64'(tq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      t = get_tr(i);
      check($sformatf("ooo_pc%0d", i), 64'(t.pc), 64'(32'h300 + 32'(4 * i)));
      check($sformatf("ooo_cyc%0d", i), 64'(t.cyc), 64'(n0 + i + LAT));
    end

    // Illegal completions: unallocated seq 7 and duplicates are ignored
    do_reset();
    alloc_val = 1'b1;
    repeat (3) step();
    alloc_val = 1'b0;
    tq.delete();
    cmpl(7, 32'h7770, 5'd7, 32'hDEAD, 1'b1);
    step();
    cmpl(1, 32'h404, 5'd1, 32'h11, 1'b1);
    step();
    cmpl(1, 32'h404, 5'd1, 32'hDEAD, 1'b1);
    step();
    idle_in();
    settle();
    check("ill_hold", 64'(tq.size()), 64'd0);
    check("ill_not_empty", 64'(empty), 64'd0);
    cmpl(0, 32'h400, 5'd0, 32'hA0, 1'b1);
    step();
    cmpl(0, 32'h400, 5'd0, 32'hDEAD, 1'b1);
    step();
    cmpl(2, 32'h408, 5'd2, 32'h22, 1'b1);
    step();
    idle_in();
    repeat (3) step();
    check("ill_count", 64'(tq.size()), 64'd3);
    t = get_tr(0);
    check("ill_wdata0", 64'(t.wdata), 64'h0A0);
    t = get_tr(1);
    check("ill_wdata1", 64'(t.wdata), 64'h011);
    check("ill_pc1", 64'(t.pc), 64'h404);
    t = get_tr(2);
    check("ill_wdata2", 64'(t.wdata), 64'h022);
    check("ill_empty", 64'(empty), 64'd1);

    // Full table, then allocation in the same cycle as a commit
    do_reset();
    alloc_val = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      check($sformatf("full_grant%0d", i), 64'(alloc_seq_num), 64'(i));
      step();
    end
    settle();
    check("full_rdy33", 64'(alloc_rdy), 64'd0);
    step();
    settle();
    check("full_rdy34", 64'(alloc_rdy), 64'd0);
    cmpl(0, 32'h600, 5'd6, 32'h6000, 1'b1);
    n0  = cyc_n;
    hit = -1;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (trace_val === 1'b1) begin
        hit = cyc_n;
        check("full_commit_rdy", 64'(alloc_rdy), 64'd0);
        break;
      end
      step();
      cmpl_val = 1'b0;
    end
    check("full_commit_cyc", 64'(hit), 64'(n0 + LAT));
    step();
    cmpl_val = 1'b0;
    settle();
    check("full_after_rdy", 64'(alloc_rdy), 64'd1);
    check("full_after_seq", 64'(alloc_seq_num), 64'd0);
    step();
    alloc_val = 1'b0;
    settle();
    check("full_refill_rdy", 64'(alloc_rdy), 64'd0);

    // Wrap: 40 instructions through the 32-entry table
    do_reset();
    tq.delete();
    at = 0;
    ci = 0;
    for (int k = 0; k < 300 && (at < 40 || ci < 40); k++) begin
      alloc_val = (at < 40);
      if (ci < at && k >= 32)
        cmpl(ci % DEPTH, 32'h1000 + 32'(4 * ci), 5'(ci), 32'hA500_0000 + 32'(ci), ci[0]);
      else
        cmpl_val = 1'b0;
      settle();
      if (alloc_val && alloc_rdy) begin
        check($sformatf("wrap_grant%0d", at), 64'(alloc_seq_num), 64'(at % DEPTH));
        at++;
      end
      if (cmpl_val) ci++;
      step();
    end
    idle_in();
    repeat (4) step();
    check("wrap_cmpl_total", 64'(ci), 64'd40);
    check("wrap_count", 64'(tq.size()), 64'd40);
    for (int i = 0; i < 40; i++) begin
      t = get_tr(i);
      check($sformatf("wrap_pc_wdata%0d", i), {t.pc, t.wdata},
            {32'h1000 + 32'(4 * i), 32'hA500_0000 + 32'(i)});
      check($sformatf("wrap_wen_waddr%0d", i), 64'({t.wen, t.waddr}),
            64'({i[0], i[4:0]}));
    end
    settle();
    check("wrap_empty", 64'(empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
